// File: rtl/cipher_sched.sv
`default_nettype none
// ============================================================================
// Module   : cipher_sched
// Brief    : Two-requester round-robin scheduler for a single cipher core,
//            with key-reload suppression and a RUN-state timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module cipher_sched #(
  parameter int TIMEOUT_CYC = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [71:0] req_data,
  input  logic [31:0] req_key,
  input  logic [1:0]  req_mode,
  output logic        core_key_load,
  output logic        core_start,
  output logic [35:0] core_data,
  output logic [15:0] core_key,
  output logic        core_mode,
  input  logic        core_done,
  input  logic [35:0] core_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [35:0] rsp_data,
  output logic        rsp_err
);

  localparam logic [2:0]  c_st_idle  = 3'd0;
  localparam logic [2:0]  c_st_load  = 3'd1;
  localparam logic [2:0]  c_st_start = 3'd2;
  localparam logic [2:0]  c_st_run   = 3'd3;
  localparam logic [2:0]  c_st_resp  = 3'd4;
  localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYC - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic        r_ptr;
  logic        r_cache_vld;
  logic [15:0] r_cache_key;
  logic [15:0] r_cnt;
  logic [35:0] r_data;
  logic [15:0] r_key;
  logic        r_mode;
  logic        r_id;
  logic [35:0] r_rsp_data;
  logic        r_rsp_err;

  logic        w_grant_id;
  logic        w_xfer;
  logic        w_key_miss;
  logic        w_timeout;

  // Contention resolves by the pointer; otherwise the lone valid requester wins.
  always_comb begin
    w_grant_id = (req_valid == 2'b11) ? r_ptr : req_valid[1];
    w_xfer     = (r_state == c_st_idle) && (|req_valid);
    w_key_miss = !r_cache_vld || (r_key != r_cache_key);
    w_timeout  = !core_done && (r_cnt == c_timeout_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (|req_valid) w_next_state = c_st_load;
      c_st_load:  w_next_state = c_st_start;
      c_st_start: w_next_state = c_st_run;
      c_st_run:   if (core_done || w_timeout) w_next_state = c_st_resp;
      c_st_resp:  if (rsp_ready) w_next_state = c_st_idle;
      default:    w_next_state = c_st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= 1'b0;
      r_cache_vld <= 1'b0;
      r_cache_key <= 16'h0;
      r_cnt       <= 16'h0;
      r_data      <= 36'h0;
      r_key       <= 16'h0;
      r_mode      <= 1'b0;
      r_id        <= 1'b0;
      r_rsp_data  <= 36'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_id   <= w_grant_id;
        r_data <= w_grant_id ? req_data[71:36] : req_data[35:0];
        r_key  <= w_grant_id ? req_key[31:16]  : req_key[15:0];
        r_mode <= req_mode[w_grant_id];
      end
      if (r_state == c_st_load && w_key_miss) begin
        r_cache_key <= r_key;
        r_cache_vld <= 1'b1;
      end
      if (r_state == c_st_start) begin
        r_cnt <= 16'h0;
      end
      if (r_state == c_st_run) begin
        if (core_done) begin
          r_rsp_data <= core_result;
          r_rsp_err  <= 1'b0;
        end else if (w_timeout) begin
          // The core state is unknown after an abort, so force a key reload.
          r_rsp_data  <= 36'h0;
          r_rsp_err   <= 1'b1;
          r_cache_vld <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 16'h1;
        end
      end
      if (r_state == c_st_resp && rsp_ready) begin
        r_ptr <= ~r_id;
      end
    end
  end

  // Outputs are gated by rst so they read zero for the whole reset window.
  always_comb begin
    req_ready     = 2'b00;
    core_key_load = 1'b0;
    core_start    = 1'b0;
    core_data     = 36'h0;
    core_key      = 16'h0;
    core_mode     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_id        = 1'b0;
    rsp_data      = 36'h0;
    rsp_err       = 1'b0;
    if (!rst) begin
      case (r_state)
        c_st_idle: begin
          if (|req_valid) req_ready = w_grant_id ? 2'b10 : 2'b01;
        end
        c_st_load: begin
          core_key_load = w_key_miss;
          core_data     = r_data;
          core_key      = r_key;
          core_mode     = r_mode;
        end
        c_st_start: begin
          core_start = 1'b1;
          core_data  = r_data;
          core_key   = r_key;
          core_mode  = r_mode;
        end
        c_st_run: begin
          core_data = r_data;
          core_key  = r_key;
          core_mode = r_mode;
        end
        c_st_resp: begin
          rsp_valid = 1'b1;
          rsp_id    = r_id;
          rsp_data  = r_rsp_data;
          rsp_err   = r_rsp_err;
        end
        default: begin
          req_ready = 2'b00;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cipher_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cipher_sched
// Brief    : Directed vector bench for cipher_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cipher_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [71:0] req_data;
  logic [31:0] req_key;
  logic [1:0]  req_mode;
  logic        core_key_load;
  logic        core_start;
  logic [35:0] core_data;
  logic [15:0] core_key;
  logic        core_mode;
  logic        core_done;
  logic [35:0] core_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [35:0] rsp_data;
  logic        rsp_err;

  always #5 clk = ~clk;

  cipher_sched #(.TIMEOUT_CYC(200)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_key(req_key), .req_mode(req_mode),
    .core_key_load(core_key_load), .core_start(core_start), .core_data(core_data),
    .core_key(core_key), .core_mode(core_mode), .core_done(core_done),
    .core_result(core_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [35:0] d0;
    logic [35:0] d1;
    logic [15:0] k0;
    logic [15:0] k1;
    logic [1:0]  mode;
    int          n;      // core_done at transfer+2+n; negative = never
    logic [35:0] res;
    int          hold;   // cycles rsp_ready stays low once rsp_valid is seen
    logic        gid;
    int          kl;
    int          rsp;
    logic        err;
    logic [35:0] rdata;
    logic [35:0] cdata;
    logic [15:0] ckey;
    logic        cmode;
  } vec_t;

  vec_t vecs[9];

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_vec(input vec_t v, input string tag);
    int kl_cnt, kl_cyc, st_cnt, st_cyc, rsp_cyc, ready_bad, unstable;
    logic [35:0] cd, rdat;
    logic [15:0] ck;
    logic cm, rid, rerr;
    bit done;
    kl_cnt = 0; kl_cyc = -1; st_cnt = 0; st_cyc = -1; rsp_cyc = -1;
    ready_bad = 0; unstable = 0; done = 0;
    cd = 36'h0; rdat = 36'h0; ck = 16'h0; cm = 1'b0; rid = 1'b0; rerr = 1'b0;
    req_valid = v.valid; req_data = {v.d1, v.d0}; req_key = {v.k1, v.k0};
    req_mode = v.mode; rsp_ready = 1'b0; core_done = 1'b0;
    #1;
    chk($sformatf("%s grant", tag), {62'h0, req_ready}, v.gid ? 64'h2 : 64'h1);
    @(posedge clk); #1;
    req_data = '1; req_key = '1; req_mode = ~v.mode;
    for (int k = 1; k <= 400 && !done; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) ready_bad++;
      if (core_key_load) begin kl_cnt++; kl_cyc = k; end
      if (core_start) begin
        st_cnt++; st_cyc = k; cd = core_data; ck = core_key; cm = core_mode;
      end
      if (rsp_valid) begin
        if (rsp_cyc < 0) begin
          rsp_cyc = k; rid = rsp_id; rdat = rsp_data; rerr = rsp_err;
        end else if (rsp_id !== rid || rsp_data !== rdat || rsp_err !== rerr) begin
          unstable++;
        end
      end
      core_done   = (v.n >= 0) && (k == 2 + v.n);
      core_result = core_done ? v.res : 36'hBADBADBAD;
      if (rsp_cyc >= 0 && (k - rsp_cyc) >= v.hold) begin
        rsp_ready = 1'b1;
        done = 1;
      end
    end
    chk($sformatf("%s rsp_seen", tag), {63'h0, done}, 64'h1);
    @(negedge clk);
    rsp_ready = 1'b0; core_done = 1'b0; req_valid = 2'b00;
    chk($sformatf("%s back_idle", tag), {63'h0, rsp_valid}, 64'h0);
    chk($sformatf("%s keyload_cnt", tag), 64'(kl_cnt), 64'(v.kl));
    chk($sformatf("%s keyload_cyc", tag), 64'(kl_cyc), v.kl != 0 ? 64'h1 : '1);
    chk($sformatf("%s start_cnt", tag), 64'(st_cnt), 64'h1);
    chk($sformatf("%s start_cyc", tag), 64'(st_cyc), 64'h2);
    chk($sformatf("%s rsp_cyc", tag), 64'(rsp_cyc), 64'(v.rsp));
    chk($sformatf("%s rsp_id", tag), {63'h0, rid}, {63'h0, v.gid});
    chk($sformatf("%s rsp_err", tag), {63'h0, rerr}, {63'h0, v.err});
    chk($sformatf("%s rsp_data", tag), {28'h0, rdat}, {28'h0, v.rdata});
    chk($sformatf("%s core_data", tag), {28'h0, cd}, {28'h0, v.cdata});
    chk($sformatf("%s core_key", tag), {48'h0, ck}, {48'h0, v.ckey});
    chk($sformatf("%s core_mode", tag), {63'h0, cm}, {63'h0, v.cmode});
    chk($sformatf("%s ready_busy", tag), 64'(ready_bad), 64'h0);
    chk($sformatf("%s rsp_stable", tag), 64'(unstable), 64'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk($sformatf("%s core_outs", tag),
        {10'h0, core_key_load, core_start, core_data, core_key, core_mode}, 64'h0);
    chk($sformatf("%s rsp_outs", tag),
        {23'h0, req_ready, rsp_valid, rsp_id, rsp_data, rsp_err}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vec_t v;
    vecs[0] = '{2'b01, 36'h123456789, 36'h0, 16'hA5A5, 16'h0, 2'b00, 5, 36'h0FEDCBA98, 0,
                1'b0, 1, 8, 1'b0, 36'h0FEDCBA98, 36'h123456789, 16'hA5A5, 1'b0};
    vecs[1] = '{2'b01, 36'h00000ABCD, 36'h0, 16'hA5A5, 16'h0, 2'b00, 3, 36'h111111111, 0,
                1'b0, 0, 6, 1'b0, 36'h111111111, 36'h00000ABCD, 16'hA5A5, 1'b0};
    vecs[2] = '{2'b11, 36'hAAAAAAAAA, 36'h555555555, 16'hA5A5, 16'h1234, 2'b10, 1, 36'h222222222, 0,
                1'b1, 1, 4, 1'b0, 36'h222222222, 36'h555555555, 16'h1234, 1'b1};
    vecs[3] = '{2'b11, 36'h3C3C3C3C3, 36'h0C0C0C0C0, 16'hA5A5, 16'h1234, 2'b10, 2, 36'h333333333, 0,
                1'b0, 1, 5, 1'b0, 36'h333333333, 36'h3C3C3C3C3, 16'hA5A5, 1'b0};
    vecs[4] = '{2'b11, 36'h0F0F0F0F0, 36'h0E0E0E0E0, 16'h1234, 16'hA5A5, 2'b11, 1, 36'h444444444, 0,
                1'b1, 0, 4, 1'b0, 36'h444444444, 36'h0E0E0E0E0, 16'hA5A5, 1'b1};
    vecs[5] = '{2'b10, 36'h0, 36'h987654321, 16'h0, 16'h1234, 2'b10, 4, 36'h555555555, 10,
                1'b1, 1, 7, 1'b0, 36'h555555555, 36'h987654321, 16'h1234, 1'b1};
    vecs[6] = '{2'b01, 36'h000000001, 36'h0, 16'h1234, 16'h0, 2'b00, -1, 36'h0, 0,
                1'b0, 0, 203, 1'b1, 36'h0, 36'h000000001, 16'h1234, 1'b0};
    vecs[7] = '{2'b01, 36'h000000002, 36'h0, 16'h1234, 16'h0, 2'b01, 1, 36'h666666666, 0,
                1'b0, 1, 4, 1'b0, 36'h666666666, 36'h000000002, 16'h1234, 1'b1};
    vecs[8] = '{2'b01, 36'h000000003, 36'h0, 16'h1234, 16'h0, 2'b00, 200, 36'h777777777, 0,
                1'b0, 0, 203, 1'b0, 36'h777777777, 36'h000000003, 16'h1234, 1'b0};

    rst = 1'b1; req_valid = 2'b01; req_data = '0; req_key = '0; req_mode = '0;
    core_done = 1'b0; core_result = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0; req_valid = 2'b00;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // core_done while idle must be ignored
    core_done = 1'b1; core_result = 36'hFFFFFFFFF;
    @(negedge clk);
    core_done = 1'b0;
    chk("idle_done_ignored", {61'h0, rsp_valid, core_start, core_key_load}, 64'h0);
    @(negedge clk);
    chk("idle_done_ignored2", {63'h0, rsp_valid}, 64'h0);

    // Reset while RUN: everything clears, no response, next block reloads key
    req_valid = 2'b01; req_data = {36'h0, 36'h0CAFEF00D}; req_key = {16'h0, 16'hA5A5};
    req_mode = 2'b00;
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    rst = 1'b1; req_valid = 2'b11;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst = 1'b0; req_valid = 2'b00;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid || core_start || core_key_load) bad++;
      core_done = (k == 3);
    end
    core_done = 1'b0;
    chk("post_reset_quiet", 64'(bad), 64'h0);

    v = '{2'b11, 36'h0CAFEF00D, 36'h0BEEF0000, 16'hA5A5, 16'h1234, 2'b00, 2, 36'h888888888, 0,
          1'b0, 1, 5, 1'b0, 36'h888888888, 36'h0CAFEF00D, 16'hA5A5, 1'b0};
    run_vec(v, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
